// File: rtl/sector_buf_pkg.sv
// sector_buf_pkg: shared read-FSM state type and sector sizing helper for sector_buf_ctrl
package sector_buf_pkg;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  function automatic int unsigned sector_words(input int unsigned asize);
    return 32'd1 << (asize - 1);
  endfunction
endpackage

// File: rtl/sector_buf_ctrl.sv
// sector_buf_ctrl: ping-pong sector buffer controller driving an external dual-port RAM
// Ports: clk/rst (async, active-high), flush (sync abort);
//   wr_valid/wr_data/wr_ready producer stream; rd_valid/rd_data/rd_ready/rd_last consumer stream;
//   ram_wclken/ram_waddr/ram_wdata/ram_wfull RAM write side; ram_rclken/ram_raddr/ram_rdata RAM read side
//   (registered, 1-cycle latency); bank_full per-bank full flags.
// Optional: define SECTOR_BUF_STATS_EN to add a 16-bit sector_cnt output counting released sectors.
module sector_buf_ctrl
  import sector_buf_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [DSIZE-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [DSIZE-1:0] rd_data,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             ram_wclken,
  output logic [ASIZE-1:0] ram_waddr,
  output logic [DSIZE-1:0] ram_wdata,
  output logic             ram_wfull,
  output logic             ram_rclken,
  output logic [ASIZE-1:0] ram_raddr,
  input  logic [DSIZE-1:0] ram_rdata,
  output logic [1:0]       bank_full
`ifdef SECTOR_BUF_STATS_EN
  ,
  output logic [15:0]      sector_cnt
`endif
);
  localparam int AW = ASIZE - 1;
  localparam logic [AW-1:0] LAST = AW'(sector_words(ASIZE) - 1);
  rd_state_e state_q, state_d;
  logic [1:0] bank_full_q, bank_full_d, set_mask, clr_mask;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, rcnt_inc;
  logic wr_fire, wr_wrap, rd_fire, rd_start, rd_release;
  assign wr_ready   = !bank_full_q[wr_bank_q] && !flush;
  // rst gating keeps the RAM untouched in the reset cycle even though wr_ready reads 1
  assign wr_fire    = wr_valid && wr_ready && !rst;
  assign wr_wrap    = wr_fire && (wcnt_q == LAST);
  assign ram_wclken = wr_fire;
  assign ram_waddr  = {wr_bank_q, wcnt_q};
  assign ram_wdata  = wr_data;
  assign ram_wfull  = bank_full_q[wr_bank_q];
  assign bank_full  = bank_full_q;
  assign rd_data    = ram_rdata;
  assign rcnt_inc   = rcnt_q + AW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R_IDLE;
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
    end
  end
  always_comb begin
    state_d = flush ? R_IDLE : rd_start ? R_DATA : rd_release ? R_IDLE : state_q;
  end
  // RAM output is registered and only advances on ram_rclken, so rd_data holds while stalled
  always_comb begin
    rd_valid   = (state_q == R_DATA) && !flush;
    rd_last    = rd_valid && (rcnt_q == LAST);
    rd_fire    = rd_valid && rd_ready;
    rd_release = rd_fire && rd_last;
    rd_start   = (state_q == R_IDLE) && bank_full_q[rd_bank_q] && !flush;
    ram_rclken = rd_start || (rd_fire && !rd_last);
    ram_raddr  = {rd_bank_q, rd_start ? {AW{1'b0}} : rcnt_inc};
  end
  // a bank being filled is never full and a bank being released always is, so set/clear never collide
  always_comb begin
    set_mask    = wr_wrap ? (2'b01 << wr_bank_q) : 2'b00;
    clr_mask    = rd_release ? (2'b01 << rd_bank_q) : 2'b00;
    bank_full_d = flush ? 2'b00 : (bank_full_q | set_mask) & ~clr_mask;
    wcnt_d      = flush ? '0 : wr_fire ? wcnt_q + AW'(1) : wcnt_q;
    wr_bank_d   = flush ? 1'b0 : wr_bank_q ^ wr_wrap;
    rd_bank_d   = flush ? 1'b0 : rd_bank_q ^ rd_release;
    rcnt_d      = (flush || rd_start) ? '0 : (rd_fire && !rd_last) ? rcnt_inc : rcnt_q;
  end
`ifdef SECTOR_BUF_STATS_EN
  logic [15:0] sector_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sector_cnt_q <= '0;
    else if (flush) sector_cnt_q <= '0;
    else if (rd_release) sector_cnt_q <= sector_cnt_q + 16'd1;
  end
  assign sector_cnt = sector_cnt_q;
`endif
endmodule

// File: tb/tb_sector_buf_ctrl.sv
// tb_sector_buf_ctrl: directed self-checking bench for sector_buf_ctrl (ASIZE=4, SECTOR=8, DSIZE=8)
module tb_sector_buf_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready;
  logic rd_valid;
  logic [7:0] rd_data;
  logic rd_ready = 1'b0;
  logic rd_last;
  logic ram_wclken;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic ram_wfull;
  logic ram_rclken;
  logic [3:0] ram_raddr;
  logic [7:0] ram_rdata;
  logic [1:0] bank_full;
`ifdef SECTOR_BUF_STATS_EN
  logic [15:0] sector_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [16];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wclken) mem[ram_waddr] <= ram_wdata;
    if (ram_rclken) ram_rdata <= mem[ram_raddr];
  end
  sector_buf_ctrl #(.DSIZE(8), .ASIZE(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .rd_last(rd_last),
    .ram_wclken(ram_wclken), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wfull(ram_wfull),
    .ram_rclken(ram_rclken), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .bank_full(bank_full)
`ifdef SECTOR_BUF_STATS_EN
    , .sector_cnt(sector_cnt)
`endif
  );
  typedef struct {
    logic wv; logic [7:0] wd; logic rr;
    logic ewr; logic ewc; logic [3:0] ewa;
    logic erv; logic [7:0] erd; logic erl; logic [1:0] ebf;
  } vec_t;
  vec_t tv [18];
  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr, input logic ewr,
                              input logic ewc, input logic [3:0] ewa, input logic erv,
                              input logic [7:0] erd, input logic erl, input logic [1:0] ebf);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.ewr = ewr; v.ewc = ewc; v.ewa = ewa;
    v.erv = erv; v.erd = erd; v.erl = erl; v.ebf = ebf;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic write_words(input logic [7:0] base, input int n, input logic [3:0] addr0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data = base + 8'(i);
      #1;
      chk("wr_ready", 32'(wr_ready), 32'(1'b1));
      chk("wr_clken", 32'(ram_wclken), 32'(1'b1));
      chk("wr_addr", 32'(ram_waddr), 32'(addr0 + 4'(i)));
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  task automatic read_words(input logic [7:0] base, input int n, input logic bank);
    int got = 0;
    int nreq = 0;
    int cyc = 0;
    rd_ready = 1'b1;
    #1;
    while (got < n && cyc < 100) begin
      if (ram_rclken) begin
        chk("rd_raddr", 32'(ram_raddr), 32'({bank, 3'(nreq)}));
        nreq++;
      end
      if (rd_valid) begin
        chk("rd_data", 32'(rd_data), 32'(base + 8'(got)));
        chk("rd_last", 32'(rd_last), 32'(got == 7));
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        #1;
      end
      cyc++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: got %0d words expected %0d", got, n);
    end
    @(negedge clk);
    rd_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int got;
    int rel_cyc;
    logic prev_stall;
    logic [7:0] prev_data;
    for (int i = 0; i < 8; i++)
      tv[i] = mk(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 4'(i), 1'b0, 8'h00, 1'b0, 2'b00);
    tv[8] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'b01);
    for (int k = 0; k < 8; k++)
      tv[9+k] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'(k), k == 7, 2'b01);
    tv[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'b00);
    wr_valid = 1'b1;
    #3;
    chk("rst_wr_ready", 32'(wr_ready), 32'(1'b1));
    chk("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
    chk("rst_rd_last", 32'(rd_last), 32'(1'b0));
    chk("rst_wclken", 32'(ram_wclken), 32'(1'b0));
    chk("rst_rclken", 32'(ram_rclken), 32'(1'b0));
    chk("rst_bank_full", 32'(bank_full), 32'(2'b00));
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      wr_valid = tv[k].wv;
      wr_data = tv[k].wd;
      rd_ready = tv[k].rr;
      #1;
      chk("tv_wr_ready", 32'(wr_ready), 32'(tv[k].ewr));
      chk("tv_wclken", 32'(ram_wclken), 32'(tv[k].ewc));
      if (tv[k].ewc) chk("tv_waddr", 32'(ram_waddr), 32'(tv[k].ewa));
      chk("tv_rd_valid", 32'(rd_valid), 32'(tv[k].erv));
      if (tv[k].erv) chk("tv_rd_data", 32'(rd_data), 32'(tv[k].erd));
      chk("tv_rd_last", 32'(rd_last), 32'(tv[k].erl));
      chk("tv_bank_full", 32'(bank_full), 32'(tv[k].ebf));
    end
`ifdef SECTOR_BUF_STATS_EN
    chk("stats_one", 32'(sector_cnt), 32'd1);
`endif
    rd_ready = 1'b0;
    write_words(8'h10, 8, 4'h8);
    write_words(8'h18, 8, 4'h0);
    wr_valid = 1'b1;
    wr_data = 8'h20;
    #1;
    chk("both_full", 32'(bank_full), 32'(2'b11));
    chk("both_full_wr_ready", 32'(wr_ready), 32'(1'b0));
    chk("both_full_wfull", 32'(ram_wfull), 32'(1'b1));
    chk("17th_wclken", 32'(ram_wclken), 32'(1'b0));
    chk("stall_rd_valid", 32'(rd_valid), 32'(1'b1));
    chk("stall_rd_data", 32'(rd_data), 32'h10);
    got = 0;
    rel_cyc = -10;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      @(negedge clk);
      rd_ready = (cyc % 2 == 1);
      if (cyc == rel_cyc + 2) wr_valid = 1'b0;
      #1;
      if (cyc == rel_cyc + 1) begin
        chk("rel_wr_ready_rise", 32'(wr_ready), 32'(1'b1));
        chk("rel_wclken", 32'(ram_wclken), 32'(1'b1));
        chk("rel_waddr", 32'(ram_waddr), 32'h8);
      end
      if (rd_valid) begin
        if (prev_stall) chk("stall_stable", 32'(rd_data), 32'(prev_data));
        if (rd_ready) begin
          chk("tog_rd_data", 32'(rd_data), 32'(8'h10 + 8'(got)));
          chk("tog_rd_last", 32'(rd_last), 32'(got % 8 == 7));
          if (got == 7) begin
            chk("rel_wr_ready_same", 32'(wr_ready), 32'(1'b0));
            rel_cyc = cyc;
          end
          got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data = rd_data;
        end
      end else prev_stall = 1'b0;
    end
    if (got < 16) begin
      checks++;
      errors++;
      $display("FAIL tog_timeout: got %0d words expected 16", got);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("tog_bank_full", 32'(bank_full), 32'(2'b00));
`ifdef SECTOR_BUF_STATS_EN
    chk("stats_three", 32'(sector_cnt), 32'd3);
`endif
    write_words(8'h50, 5, 4'h9);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h55;
    #1;
    chk("flush_wr_ready", 32'(wr_ready), 32'(1'b0));
    chk("flush_wclken", 32'(ram_wclken), 32'(1'b0));
    chk("flush_rd_valid", 32'(rd_valid), 32'(1'b0));
    @(negedge clk);
    flush = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("post_flush_bank_full", 32'(bank_full), 32'(2'b00));
`ifdef SECTOR_BUF_STATS_EN
    chk("stats_flush", 32'(sector_cnt), 32'd0);
`endif
    write_words(8'hA0, 8, 4'h0);
    read_words(8'hA0, 8, 1'b0);
    write_words(8'hC0, 8, 4'h8);
    read_words(8'hC0, 3, 1'b1);
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    #1;
    chk("mid_rd_data", 32'(rd_data), 32'hC3);
    chk("mid_bank_full", 32'(bank_full), 32'(2'b10));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'(1'b0));
    chk("arst_rd_last", 32'(rd_last), 32'(1'b0));
    chk("arst_bank_full", 32'(bank_full), 32'(2'b00));
    chk("arst_wr_ready", 32'(wr_ready), 32'(1'b1));
    chk("arst_wclken", 32'(ram_wclken), 32'(1'b0));
    chk("arst_rclken", 32'(ram_rclken), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    write_words(8'hD0, 8, 4'h0);
    read_words(8'hD0, 8, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sector_buf_ctrl.md
SECTOR_BUF_CTRL -- requirements
Module: sector_buf_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width.
REQ-002 SHALL have parameter ASIZE, default 10, RAM address width; MSB selects bank, so each bank holds SECTOR = 2^(ASIZE-1) words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous abort; clears both banks.
REQ-006 SHALL have ports wr_valid  input  1;  wr_data  input  DSIZE;  wr_ready  output  1  (producer stream).
REQ-007 SHALL have ports rd_valid  output  1;  rd_data  output  DSIZE;  rd_ready  input  1;  rd_last  output  1  (final word of sector).
REQ-008 SHALL have ports ram_wclken  output  1;  ram_waddr  output  ASIZE;  ram_wdata  output  DSIZE;  ram_wfull  output  1  (to external dual-port RAM write side).
REQ-009 SHALL have ports ram_rclken  output  1;  ram_raddr  output  ASIZE;  ram_rdata  input  DSIZE  (RAM read side, registered, 1-cycle latency).
REQ-010 SHALL have port bank_full  output  2  per-bank full flags.

Function
REQ-011 Write side SHALL hold wr_bank pointer and (ASIZE-1)-bit wcnt; wr_ready = !bank_full[wr_bank] && !flush.
REQ-012 On wr_valid && wr_ready, ram_wclken SHALL be 1 combinationally, ram_waddr = {wr_bank, wcnt}, ram_wdata = wr_data; wcnt increments.
REQ-013 When wcnt = SECTOR-1 is written, bank_full[wr_bank] SHALL set, wcnt wraps to 0, wr_bank toggles, all in the same edge.
REQ-014 ram_wfull SHALL equal bank_full[wr_bank].
REQ-015 Read FSM states: R_IDLE, R_DATA.
REQ-016 R_IDLE: when bank_full[rd_bank], SHALL assert ram_rclken with ram_raddr = {rd_bank, 0}, rcnt = 0, go R_DATA; rd_valid = 0.
REQ-017 R_DATA: rd_valid = 1, rd_data = ram_rdata, rd_last = (rcnt = SECTOR-1).
REQ-018 R_DATA handshake, not last: SHALL assert ram_rclken at {rd_bank, rcnt+1}, increment rcnt, remain R_DATA (one word per cycle sustained).
REQ-019 R_DATA handshake with rd_last: SHALL clear bank_full[rd_bank], toggle rd_bank, go R_IDLE.
REQ-020 R_DATA without rd_ready: ram_rclken = 0; rd_data SHALL stay stable.
REQ-021 Latency: first rd_valid SHALL appear 2 cycles after the edge that sets bank_full.
REQ-022 Release of bank X and writer stalled on X in same cycle: wr_ready SHALL rise the next cycle, not the same cycle.
REQ-023 Both banks full: wr_ready = 0 until a release.
REQ-024 flush SHALL, on the next edge, clear bank_full, wcnt, rcnt, wr_bank, rd_bank and force R_IDLE; while flush = 1, ram_wclken = 0, ram_rclken = 0, rd_valid = 0.

Reset
REQ-025 rst SHALL asynchronously force: bank_full = 0, wr_bank = rd_bank = 0, wcnt = rcnt = 0, state R_IDLE; hence wr_ready = 1, rd_valid = 0, rd_last = 0, ram_wclken = ram_rclken = 0.
REQ-026 rst mid-sector SHALL discard partial and full banks with no RAM access in the reset cycle.

Configuration
REQ-027 Macro SECTOR_BUF_STATS_EN defined: SHALL add output sector_cnt (16 bits), +1 per released sector, wraps at 65535 to 0, cleared by rst and flush.
REQ-028 Macro undefined: sector_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package sector_buf_pkg SHALL hold the read-state enum (R_IDLE, R_DATA) and a function returning SECTOR from ASIZE.
REQ-030 No sub-module instantiated; the RAM stays outside the block at the top level.

Verification (ASIZE = 4, SECTOR = 8, DSIZE = 8)
REQ-031 Write 0x00..0x07, rd_ready = 1 -> bank_full = 01, rd_valid 2 cycles later, reads 0x00..0x07 back-to-back, rd_last on 0x07, bank_full = 00.
REQ-032 rd_ready = 0, write 16 words 0x10..0x1F -> bank_full = 11, wr_ready = 0, 17th word not written (ram_wclken = 0).
REQ-033 From REQ-032 state, rd_ready toggling every other cycle -> 0x10..0x1F in order, rd_data stable while stalled, wr_ready rises one cycle after first release.
REQ-034 Write 5 words, pulse flush, write 0xA0..0xA7 -> read yields 0xA0..0xA7 at addresses 0..7, no stale data.
REQ-035 Assert rst during R_DATA at rcnt = 3 -> all outputs at reset values immediately, next sector read from address 0.
REQ-036 With SECTOR_BUF_STATS_EN, stream 3 sectors -> sector_cnt = 3; after flush sector_cnt = 0.
